// File: rtl/nird_joint_hist.sv
// 10x10 joint histogram of riu2 NI/RD codes over a frame; on frame end streams
// all bins over valid/ready (valid 1 cycle after the pulse, holds on stall), clearing each as read.
module nird_joint_hist #(
  parameter int COLS  = 30,
  parameter int ROWS  = 30,
  parameter int BIN_W = $clog2(COLS*ROWS+1),
  parameter int NBINS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ni_i,
  input  logic [3:0]       rd_i,
  input  logic             done_i,
  input  logic             progress_done_i,
  output logic             in_ready_o,
  output logic [BIN_W-1:0] hist_o,
  output logic [6:0]       hist_idx_o,
  output logic             hist_valid_o,
  output logic             hist_last_o,
  input  logic             hist_ready_i,
  output logic [BIN_W:0]   total_o,
  output logic             frame_done_o,
  output logic             code_err_o,
  output logic             drop_o
);

  localparam int         NB2      = NBINS*NBINS;
  localparam logic [6:0] LAST_IDX = 7'(NB2-1);

  typedef enum logic {ACCUM, DUMP} state_t;

  state_t           state_q;
  logic [BIN_W-1:0] bin_q [NB2];
  logic [BIN_W:0]   total_q, total_d, total_out_q;
  logic [6:0]       dump_idx_q, samp_idx;
  logic             code_ok, take, accept;
  logic             frame_done_q, code_err_q, drop_q;

  assign code_ok  = (ni_i < 4'(NBINS)) && (rd_i < 4'(NBINS));
  assign samp_idx = 7'(ni_i) * 7'(NBINS) + 7'(rd_i);
  assign take     = (state_q == ACCUM) && done_i && code_ok;
  assign accept   = (state_q == DUMP) && hist_ready_i;
  // Total includes a sample arriving on the same edge as the frame-end pulse.
  assign total_d  = (take && (total_q != '1)) ? total_q + 1'b1 : total_q;

  assign in_ready_o   = (state_q == ACCUM);
  assign hist_valid_o = (state_q == DUMP);
  assign hist_o       = hist_valid_o ? bin_q[dump_idx_q] : '0;
  assign hist_idx_o   = hist_valid_o ? dump_idx_q : '0;
  assign hist_last_o  = hist_valid_o && (dump_idx_q == LAST_IDX);
  assign total_o      = total_out_q;
  assign frame_done_o = frame_done_q;
  assign code_err_o   = code_err_q;
  assign drop_o       = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NB2; i++) bin_q[i] <= '0;
      state_q      <= ACCUM;
      total_q      <= '0;
      total_out_q  <= '0;
      dump_idx_q   <= '0;
      frame_done_q <= 1'b0;
      code_err_q   <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (take && (bin_q[samp_idx] != '1))
            bin_q[samp_idx] <= bin_q[samp_idx] + BIN_W'(1);
          if (done_i && !code_ok)
            code_err_q <= 1'b1;
          if (progress_done_i) begin
            total_out_q <= total_d;
            total_q     <= '0;
            dump_idx_q  <= '0;
            state_q     <= DUMP;
          end else begin
            total_q <= total_d;
          end
        end
        DUMP: begin
          if (done_i)
            drop_q <= 1'b1;
          // Read-clear leaves every bin at zero for the next frame.
          if (accept) begin
            bin_q[dump_idx_q] <= '0;
            if (dump_idx_q == LAST_IDX) begin
              dump_idx_q   <= '0;
              frame_done_q <= 1'b1;
              state_q      <= ACCUM;
            end else begin
              dump_idx_q <= dump_idx_q + 7'd1;
            end
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_nird_joint_hist.sv
// Directed bench for nird_joint_hist: default instance plus a BIN_W=4 saturation instance.
module tb_nird_joint_hist;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  ni, rd;
  logic        done, pd, rdy;
  logic        in_ready, hvalid, hlast, fdone, cerr, drop;
  logic [9:0]  hist;
  logic [6:0]  hidx;
  logic [10:0] total;

  logic [3:0]  b_ni, b_rd;
  logic        b_done, b_pd, b_rdy;
  logic        b_in_ready, b_hvalid, b_hlast, b_fdone, b_cerr, b_drop;
  logic [3:0]  b_hist;
  logic [6:0]  b_hidx;
  logic [4:0]  b_total;

  int n_checks = 0;
  int n_errors = 0;
  int exp_bin[100];

  nird_joint_hist dut (
    .clk(clk), .rst(rst), .ni_i(ni), .rd_i(rd), .done_i(done),
    .progress_done_i(pd), .in_ready_o(in_ready), .hist_o(hist),
    .hist_idx_o(hidx), .hist_valid_o(hvalid), .hist_last_o(hlast),
    .hist_ready_i(rdy), .total_o(total), .frame_done_o(fdone),
    .code_err_o(cerr), .drop_o(drop)
  );

  nird_joint_hist #(.BIN_W(4)) dut_b (
    .clk(clk), .rst(rst), .ni_i(b_ni), .rd_i(b_rd), .done_i(b_done),
    .progress_done_i(b_pd), .in_ready_o(b_in_ready), .hist_o(b_hist),
    .hist_idx_o(b_hidx), .hist_valid_o(b_hvalid), .hist_last_o(b_hlast),
    .hist_ready_i(b_rdy), .total_o(b_total), .frame_done_o(b_fdone),
    .code_err_o(b_cerr), .drop_o(b_drop)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] n, input logic [3:0] r, input logic d, input logic p);
    ni = n; rd = r; done = d; pd = p;
    @(posedge clk); #1;
    done = 1'b0; pd = 1'b0;
  endtask

  task automatic clear_exp();
    foreach (exp_bin[i]) exp_bin[i] = 0;
  endtask

  // Walks the dump word by word; optional stall, in-dump sample injection, or reset abort.
  task automatic run_dump(input int stall_at, input int drop_at, input int abort_at);
    bit aborted = 1'b0;
    int pulses  = 0;
    rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_valid", hvalid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_code_err", cerr, 0);
        check("abort_drop", drop, 0);
        check("abort_total", total, 0);
        for (int k = 0; k < 120; k++) begin
          if (fdone) pulses++;
          @(posedge clk); #1;
        end
        check("abort_no_frame_done", pulses, 0);
        aborted = 1'b1;
        break;
      end
      if (i == stall_at) begin
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          check("stall_valid", hvalid, 1);
          check("stall_idx", hidx, i);
          check("stall_bin", hist, exp_bin[i]);
        end
        rdy = 1'b1;
      end
      check("dump_valid", hvalid, 1);
      check("dump_idx", hidx, i);
      check("dump_bin", hist, exp_bin[i]);
      check("dump_last", hlast, (i == 99));
      if (i == drop_at) begin
        ni = 4'd4; rd = 4'd4; done = 1'b1;
      end
      @(posedge clk); #1;
      done = 1'b0;
    end
    if (!aborted) begin
      check("fd_pulse", fdone, 1);
      check("fd_valid", hvalid, 0);
      check("fd_last", hlast, 0);
      check("fd_in_ready", in_ready, 1);
      @(posedge clk); #1;
      check("fd_once", fdone, 0);
    end
  endtask

  initial begin
    rst = 1'b1; ni = '0; rd = '0; done = 1'b0; pd = 1'b0; rdy = 1'b1;
    b_ni = '0; b_rd = '0; b_done = 1'b0; b_pd = 1'b0; b_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_valid", hvalid, 0);
    check("rst_frame_done", fdone, 0);
    check("rst_code_err", cerr, 0);
    check("rst_drop", drop, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_last", hlast, 0);
    check("rst_total", total, 0);

    // BIN_W=4: twenty (2,7) samples saturate bin 27 at 15
    for (int k = 0; k < 20; k++) begin
      b_ni = 4'd2; b_rd = 4'd7; b_done = 1'b1; b_pd = (k == 19);
      @(posedge clk); #1;
    end
    b_done = 1'b0; b_pd = 1'b0;
    check("b_valid", b_hvalid, 1);
    check("b_total", b_total, 20);
    repeat (27) @(posedge clk);
    #1;
    check("b_idx", b_hidx, 27);
    check("b_sat", b_hist, 15);

    // Frame 1 with a 5-cycle stall at index 35
    clear_exp();
    exp_bin[0] = 2; exp_bin[35] = 3; exp_bin[99] = 1;
    repeat (3) step(4'd3, 4'd5, 1'b1, 1'b0);
    step(4'd9, 4'd9, 1'b1, 1'b0);
    step(4'd0, 4'd0, 1'b1, 1'b0);
    step(4'd0, 4'd0, 1'b1, 1'b1);
    check("f1_latency_valid", hvalid, 1);
    check("f1_in_ready", in_ready, 0);
    check("f1_total", total, 6);
    run_dump(35, -1, -1);
    check("f1_drop", drop, 0);
    check("f1_code_err", cerr, 0);

    // Empty frame; a sample injected mid-dump must be dropped
    clear_exp();
    step(4'd0, 4'd0, 1'b0, 1'b1);
    check("f2_total", total, 0);
    run_dump(-1, 10, -1);
    check("f2_drop", drop, 1);

    // Invalid code is flagged and not counted
    clear_exp();
    exp_bin[11] = 1;
    step(4'd12, 4'd3, 1'b1, 1'b0);
    check("f3_code_err", cerr, 1);
    check("f3_in_ready", in_ready, 1);
    step(4'd1, 4'd1, 1'b1, 1'b1);
    check("f3_total", total, 1);
    run_dump(-1, -1, -1);

    // Reset abandons a dump at index 40
    clear_exp();
    exp_bin[62] = 2;
    step(4'd6, 4'd2, 1'b1, 1'b0);
    step(4'd6, 4'd2, 1'b1, 1'b1);
    check("f4_total", total, 2);
    run_dump(-1, -1, 40);

    // Fresh frame after reset shows only its own sample
    clear_exp();
    exp_bin[11] = 1;
    step(4'd1, 4'd1, 1'b1, 1'b1);
    check("f5_total", total, 1);
    run_dump(-1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
